// File: rtl/lc3b_types.sv
// Shared types for the LC-3b out-of-order core.
//   cdb_state_t : common-data-bus scheduler state encoding.
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } cdb_state_t;

endpackage

// File: rtl/cdb_scheduler_rr_priority_encoder.sv
// rr_priority_encoder: combinational wrap-around priority search.
// Finds the first set bit of req scanning rr_ptr, rr_ptr+1, ..., N-1, 0, ...
// Ports:
//   req    [N-1:0] : request vector
//   rr_ptr [W-1:0] : starting position of the search (must be < N)
//   idx    [W-1:0] : index of the first request found
//   found          : req has at least one bit set
module rr_priority_encoder #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr_ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    int j;

    // Scan from the farthest offset back to offset 0 so the closest match
    // to rr_ptr is the last one written and therefore wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                idx   = W'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/macros.sv
// Global build macros for the CDB scheduler slice.
//   NUM_STATIONS : default number of stations sharing the common data bus.
// Optional feature macro (define on the command line, not here):
//   CDB_HOLDOFF_EN : insert a one-cycle HOLD bubble after every completion.
`ifndef NUM_STATIONS
`define NUM_STATIONS 4
`endif

// File: rtl/cdb_scheduler.sv
// cdb_scheduler: round-robin arbiter granting one station at a time access
// to the common data bus (CDB). A grant is held until the consumer
// acknowledges it with resp; there is no preemption.
// Ports:
//   clk         : clock, all state on rising edge
//   rst         : synchronous active-high reset
//   req [N-1:0] : station i has a completed result
//   resp        : consumer accepted the granted result
//   grant_idx   : granted station index
//   grant_valid : high in GRANT and WAIT
//   load        : one-cycle strobe to load the CDB register (GRANT state)
//   busy        : state is not IDLE
// Build option:
//   CDB_HOLDOFF_EN : when defined, every completion passes through a
//                    one-cycle HOLD bubble before returning to IDLE.
`ifndef NUM_STATIONS
`define NUM_STATIONS 4
`endif

module cdb_scheduler
    import lc3b_types::*;
#(
    parameter  int N = `NUM_STATIONS,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         resp,
    output logic [W-1:0] grant_idx,
    output logic         grant_valid,
    output logic         load,
    output logic         busy
);

    cdb_state_t   state_q, state_d;
    logic [W-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0] grant_idx_q, grant_idx_d;
    logic         grant_valid_q, grant_valid_d;
    logic         load_q, load_d;
    logic         busy_q, busy_d;

    logic [W-1:0] enc_idx;
    logic         enc_found;

    rr_priority_encoder #(.N(N)) u_enc (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .idx    (enc_idx),
        .found  (enc_found)
    );

    // Completion target state depends on the hold-off build option.
    cdb_state_t done_state;
`ifdef CDB_HOLDOFF_EN
    assign done_state = HOLD;
`else
    assign done_state = IDLE;
`endif

    // Pointer advance with explicit wrap so N-1 never overflows into an
    // out-of-range index when N is not a power of two.
    logic [W-1:0] next_ptr;
    always_comb begin
        if (int'(grant_idx_q) == N - 1) next_ptr = '0;
        else                            next_ptr = grant_idx_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        unique case (state_q)
            IDLE: begin
                if (enc_found) begin
                    grant_idx_d = enc_idx;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                // resp already present in the load cycle counts as completion
                if (resp) begin
                    rr_ptr_d = next_ptr;
                    state_d  = done_state;
                end else begin
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (resp) begin
                    rr_ptr_d = next_ptr;
                    state_d  = done_state;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, decoded from the state being entered.
        grant_valid_d = (state_d == GRANT) || (state_d == WAIT);
        load_d        = (state_d == GRANT);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            load_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            load_q        <= load_d;
            busy_q        <= busy_d;
        end
    end

    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign load        = load_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_cdb_scheduler.sv
// Directed self-checking bench for cdb_scheduler with N=4.
// Works for both builds; CDB_HOLDOFF_EN selects the expected spacing.
module tb_cdb_scheduler;

    localparam int N = 4;
`ifdef CDB_HOLDOFF_EN
    localparam int HOLD_CYC = 1;
`else
    localparam int HOLD_CYC = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         resp;
    logic [1:0]   grant_idx;
    logic         grant_valid;
    logic         load;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;
    logic prev_load = 1'b0;
    int n;

    cdb_scheduler #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .resp        (resp),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .load        (load),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the edge; also guard that load
    // never appears in two consecutive cycles.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("no_b2b_load", {31'd0, prev_load & load}, 32'd0);
        prev_load = load;
    endtask

    task automatic wait_load(output int cnt);
        cnt = 0;
        while (!load && cnt < 8) begin
            tick();
            cnt++;
        end
        chk("load_timeout", {31'd0, load}, 32'd1);
    endtask

    // Let a HOLD bubble (if built in) drain back to IDLE.
    task automatic drain();
        if (HOLD_CYC != 0) tick();
        chk("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_out(input string tag, input logic [1:0] idx,
                           input logic gv, input logic ld, input logic bz);
        chk({tag, "_idx"},  {30'd0, grant_idx},  {30'd0, idx});
        chk({tag, "_gv"},   {31'd0, grant_valid}, {31'd0, gv});
        chk({tag, "_load"}, {31'd0, load},        {31'd0, ld});
        chk({tag, "_busy"}, {31'd0, busy},        {31'd0, bz});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req = '0; resp = 1'b0;
        tick(); tick();
        chk_out("reset", 2'd0, 1'b0, 1'b0, 1'b0);

        // Single requester on bit 2: grant next cycle, hold until resp.
        rst = 1'b0; req = 4'b0100;
        tick();
        chk_out("g2_grant", 2'd2, 1'b1, 1'b1, 1'b1);
        tick();
        chk_out("g2_wait", 2'd2, 1'b1, 1'b0, 1'b1);
        resp = 1'b1; req = '0;
        tick();
        chk("g2_done_gv", {31'd0, grant_valid}, 32'd0);
        chk("g2_done_load", {31'd0, load}, 32'd0);
        resp = 1'b0;
        drain();

        // rr_ptr is 3: req=0011 wraps to station 0.
        req = 4'b0011;
        tick();
        chk_out("wrap_grant", 2'd0, 1'b1, 1'b1, 1'b1);
        tick();
        resp = 1'b1; req = '0;
        tick();
        resp = 1'b0;
        drain();
        // rr_ptr now 1: all requesting picks station 1.
        req = 4'b1111;
        tick();
        chk_out("ptr1_grant", 2'd1, 1'b1, 1'b1, 1'b1);

        // Drop the granted request bit; grant must stay frozen.
        req = 4'b1101;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_out("frozen", 2'd1, 1'b1, 1'b0, 1'b1);
        end
        resp = 1'b1; req = '0;
        tick();
        resp = 1'b0;
        drain();

        // Reset in the middle of WAIT abandons the grant.
        req = 4'b0100;
        tick();
        chk_out("pre_rst_grant", 2'd2, 1'b1, 1'b1, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        chk_out("mid_rst", 2'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; req = 4'b0111;
        tick();
        chk_out("post_rst_grant", 2'd0, 1'b1, 1'b1, 1'b1);
        resp = 1'b1; req = '0;
        tick();
        resp = 1'b0;
        drain();

        // Fairness: all requesting, resp one cycle after each load.
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_load(n);
            chk("fair_idx", {30'd0, grant_idx}, 32'(g % N));
            if (g > 0) chk("fair_gap", 32'(n), 32'(1 + HOLD_CYC));
            resp = 1'b0;
            tick();
            chk("fair_wait_load", {31'd0, load}, 32'd0);
            resp = 1'b1;
            tick();
            chk("fair_done_gv", {31'd0, grant_valid}, 32'd0);
            resp = 1'b0;
        end

        // resp in the GRANT cycle: next load 2 (or 3 with hold-off) cycles on.
        wait_load(n);
        chk("fast_idx", {30'd0, grant_idx}, 32'd1);
        resp = 1'b1;
        tick();
        chk("fast_done_gv", {31'd0, grant_valid}, 32'd0);
        resp = 1'b0;
        wait_load(n);
        chk("fast_spacing", 32'(1 + n), 32'(2 + HOLD_CYC));
        chk("fast_next_idx", {30'd0, grant_idx}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_scheduler.md
CDB_SCHEDULER -- requirements
Module: cdb_scheduler

Interface
REQ-001 SHALL have parameter N, default `NUM_STATIONS, meaning the number of requesters sharing the common data bus; legal range 2..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, N bits: bit i high means station i has a completed result for the CDB.
REQ-005 SHALL have port resp, input, 1 bit: the CDB consumer (LSQ/regfile) has accepted the granted result.
REQ-006 SHALL have port grant_idx, output, $clog2(N) bits: index of the granted station.
REQ-007 SHALL have port grant_valid, output, 1 bit: grant_idx is meaningful.
REQ-008 SHALL have port load, output, 1 bit: one-cycle strobe to load the CDB register from station grant_idx.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-010 SHALL implement states IDLE, GRANT, WAIT and HOLD, encoded as cdb_state_t.
REQ-011 IDLE: if req is nonzero, SHALL select the first set bit searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ... N-1, 0, ...), register it into grant_idx, and go to GRANT; otherwise SHALL stay in IDLE.
REQ-012 Latency: req sampled high in cycle t SHALL give grant_valid=1 and load=1 in cycle t+1.
REQ-013 GRANT: SHALL last exactly one cycle with load=1; go to WAIT, or treat resp=1 in the same cycle as completion.
REQ-014 WAIT: grant_valid=1, load=0, grant_idx frozen; SHALL leave only on resp=1.
REQ-015 Completion: SHALL set rr_ptr to (grant_idx+1) mod N, computed without overflow when grant_idx=N-1. Next state is HOLD if CDB_HOLDOFF_EN is defined, else IDLE.
REQ-016 HOLD: SHALL last one cycle with grant_valid=0 and load=0, then go to IDLE.
REQ-017 Changes on req in GRANT, WAIT or HOLD SHALL be ignored, including deassertion of the granted bit. There is no preemption.
REQ-018 resp in IDLE or HOLD SHALL be ignored with no state change.
REQ-019 grant_valid SHALL be 1 exactly in GRANT and WAIT. In IDLE and HOLD, grant_idx keeps its last value and is don't-care.
REQ-020 Fairness: with all bits of req held high, successive grants SHALL be 0,1,...,N-1,0.

Reset
REQ-021 rst=1 at a clock edge SHALL force state=IDLE, rr_ptr=0, grant_idx=0, grant_valid=0, load=0, busy=0, from any state including mid-WAIT.
REQ-022 A grant pending when rst is asserted SHALL be abandoned; rr_ptr does not advance.
REQ-023 The first possible grant after rst deasserts SHALL appear in the second cycle after deassertion.

Configuration
REQ-024 Macro CDB_HOLDOFF_EN, defined: SHALL insert the HOLD bubble after every completion, giving the LSQ one cycle to stage data. Minimum grant spacing is 4 cycles when resp arrives in WAIT.
REQ-025 Macro CDB_HOLDOFF_EN, undefined: HOLD SHALL be unreachable and completion SHALL return directly to IDLE. Minimum spacing is 3 cycles.

Structure
REQ-026 cdb_state_t SHALL be declared in package lc3b_types; N's default comes from `NUM_STATIONS in macros.sv.
REQ-027 The wrap-around search SHALL be a combinational sub-module rr_priority_encoder (inputs req, rr_ptr; outputs idx, found), reusable by other arbiters.

Verification
REQ-028 N=4, reset, then req=0100 held -> cycle+1: grant_idx=2, load=1; WAIT until resp; rr_ptr becomes 3.
REQ-029 N=4, req=1111 held, resp one cycle after each load -> grants 0,1,2,3,0 in order, load never high two consecutive cycles.
REQ-030 N=4, rr_ptr=3, req=0011 -> grant_idx=0 (wrap-around); after resp, rr_ptr=1.
REQ-031 Grant to 1, drop req[1] in WAIT, no resp for 10 cycles -> grant_valid and grant_idx=1 stay constant throughout.
REQ-032 rst pulsed during WAIT with grant_idx=2 -> next cycle all outputs 0 and state IDLE; with req=0111, next grant is 0.
REQ-033 Build with and without CDB_HOLDOFF_EN, resp in the GRANT cycle, req=1111 -> next load is 3 cycles later with the macro, 2 cycles later without it.
